// File: rtl/pix_chan_pkg.sv
// Shared definitions for the pixel channel serializer: mode values, FSM
// encoding and the width helper used to size channel indices.
package pix_chan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SERIAL = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SER  = 1'b1
  } state_t;

  // Ceiling log2, at least 1 so a channel index is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pix_chan_serializer_onehot_enc.sv
// One-hot select decoder: returns the index of the set bit and flags
// patterns with zero or several bits set.
module onehot_enc
  import pix_chan_pkg::*;
#(
  parameter int NCH = 3,
  localparam int CW = clog2(NCH)
) (
  input  logic [NCH-1:0] sel,
  output logic [CW-1:0]  idx,
  output logic           onehot_ok
);

  logic [CW:0]   hits_s;
  logic [CW-1:0] idx_s;

  // Count set bits and remember the position of the highest one.
  always_comb begin
    hits_s = '0;
    idx_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel[i]) begin
        hits_s = hits_s + {{CW{1'b0}}, 1'b1};
        idx_s  = CW'(i);
      end else begin
        hits_s = hits_s;
        idx_s  = idx_s;
      end
    end
  end

  assign idx       = idx_s;
  assign onehot_ok = (hits_s == {{CW{1'b0}}, 1'b1});

endmodule

// File: rtl/pix_chan_serializer.sv
// Routes one colour channel (DIRECT) or every channel in order (SERIAL) of a
// packed pixel onto a registered byte lane with valid/ready on both sides.
module pix_chan_serializer
  import pix_chan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 3,
  localparam int CW   = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [NCH-1:0]       sel,
  input  logic [NCH*WIDTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [WIDTH-1:0]     mux_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        chan_idx,
  output logic                 last,
  output logic                 sel_err
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [NCH*WIDTH-1:0] hold_r;
  logic [WIDTH-1:0]     mux_r;
  logic                 valid_r;
  logic [CW-1:0]        chan_r;
  logic                 last_r;
  logic                 sel_err_r;
  logic                 pix_ready_s;

  logic [WIDTH-1:0]     pix_ch_s  [NCH];
  logic [WIDTH-1:0]     hold_ch_s [NCH];
  logic [CW-1:0]        enc_idx_s;
  logic                 onehot_ok_s;
  logic                 slot_free_s;
  logic                 accept_s;
  logic                 out_hs_s;
  logic                 final_s;
  logic [CW-1:0]        chan_nxt_s;

  for (genvar g = 0; g < NCH; g++) begin : g_split
    assign pix_ch_s[g]  = pix_in[g*WIDTH +: WIDTH];
    assign hold_ch_s[g] = hold_r[g*WIDTH +: WIDTH];
  end

  onehot_enc #(.NCH(NCH)) u_enc (
    .sel       (sel),
    .idx       (enc_idx_s),
    .onehot_ok (onehot_ok_s)
  );

  assign slot_free_s = !valid_r || out_ready;
  assign out_hs_s    = valid_r && out_ready;
  assign final_s     = (chan_r == LAST_IDX);
  assign chan_nxt_s  = chan_r + CW'(1);
  assign accept_s    = pix_valid && pix_ready_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a new pixel decides by its own mode; a serial pixel ends on its final handshake.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      state_nxt_s = (mode == MODE_SERIAL) ? ST_SER : ST_IDLE;
    end else if ((state_r == ST_SER) && out_hs_s && final_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Input-side readiness; mid-pixel only the final beat may overlap the next pixel.
  always_comb begin
    pix_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: pix_ready_s = slot_free_s;
      ST_SER:  pix_ready_s = final_s && out_ready;
      default: pix_ready_s = 1'b0;
    endcase
  end

  // Hold register and registered output lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r    <= '0;
      mux_r     <= '0;
      valid_r   <= 1'b0;
      chan_r    <= '0;
      last_r    <= 1'b0;
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= 1'b0;
      if (accept_s) begin
        if (mode == MODE_SERIAL) begin
          hold_r  <= pix_in;
          mux_r   <= pix_ch_s[0];
          chan_r  <= '0;
          last_r  <= 1'b0;
          valid_r <= 1'b1;
        end else if (onehot_ok_s) begin
          mux_r   <= pix_ch_s[enc_idx_s];
          chan_r  <= enc_idx_s;
          last_r  <= 1'b1;
          valid_r <= 1'b1;
        end else begin
          // Bad select: drop the pixel, keep the lane contents, flag it.
          valid_r   <= 1'b0;
          last_r    <= 1'b0;
          sel_err_r <= 1'b1;
        end
      end else if (out_hs_s) begin
        if ((state_r == ST_SER) && !final_s) begin
          chan_r <= chan_nxt_s;
          mux_r  <= hold_ch_s[chan_nxt_s];
          last_r <= (chan_nxt_s == LAST_IDX);
        end else begin
          valid_r <= 1'b0;
        end
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign pix_ready = pix_ready_s;
  assign mux_out   = mux_r;
  assign out_valid = valid_r;
  assign chan_idx  = chan_r;
  assign last      = last_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_pix_chan_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, scored against
// a queue of expected output beats built from each accepted pixel.
module tb_pix_chan_serializer;

  localparam int WIDTH = 8;
  localparam int NCH   = 3;
  localparam int CW    = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 mode = 1'b0;
  logic [NCH-1:0]       sel = '0;
  logic [NCH*WIDTH-1:0] pix_in = '0;
  logic                 pix_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 pix_ready;
  logic [WIDTH-1:0]     mux_out;
  logic                 out_valid;
  logic [CW-1:0]        chan_idx;
  logic                 last;
  logic                 sel_err;

  always #5 clk = ~clk;

  pix_chan_serializer #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .mux_out   (mux_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .chan_idx  (chan_idx),
    .last      (last),
    .sel_err   (sel_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       fin;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] held_data;
  logic [1:0] held_idx;
  logic       exp_err;
  logic       last_acc;
  int         checks = 0;
  int         errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan_of(input logic [23:0] p, input int i);
    return p[i*8 +: 8];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    held_data = 8'h00;
    held_idx  = 2'd0;
    exp_err   = 1'b0;
    last_acc  = 1'b0;
  endtask

  // One clock: apply inputs, compare the lane with the model, then advance the model.
  task automatic cycle(input logic v, input logic m, input logic [2:0] s,
                       input logic [23:0] p, input logic ordy);
    logic exp_rdy;
    int   n_hot;
    int   hot_i;
    @(posedge clk);
    #1;
    pix_valid = v;
    mode      = m;
    sel       = s;
    pix_in    = p;
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && ordy);
    check_eq("pix_ready", 32'(pix_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("mux_out", 32'(mux_out), 32'(exp_q[0].data));
      check_eq("chan_idx", 32'(chan_idx), 32'(exp_q[0].idx));
      check_eq("last", 32'(last), 32'(exp_q[0].fin));
    end else begin
      check_eq("mux_out_held", 32'(mux_out), 32'(held_data));
      check_eq("chan_idx_held", 32'(chan_idx), 32'(held_idx));
    end
    check_eq("sel_err", 32'(sel_err), 32'(exp_err));
    if ((exp_q.size() != 0) && ordy) begin
      held_data = exp_q[0].data;
      held_idx  = exp_q[0].idx;
      void'(exp_q.pop_front());
    end
    exp_err  = 1'b0;
    last_acc = v && exp_rdy;
    if (last_acc) begin
      if (m) begin
        for (int i = 0; i < NCH; i++) begin
          exp_q.push_back('{data: chan_of(p, i), idx: 2'(i), fin: (i == NCH - 1)});
        end
      end else begin
        n_hot = 0;
        hot_i = 0;
        for (int i = 0; i < NCH; i++) begin
          if (s[i]) begin
            n_hot++;
            hot_i = i;
          end
        end
        if (n_hot == 1) exp_q.push_back('{data: chan_of(p, hot_i), idx: 2'(hot_i), fin: 1'b1});
        else exp_err = 1'b1;
      end
    end
  endtask

  initial begin
    logic        rv;
    logic        rm;
    logic [2:0]  rs;
    logic [23:0] rp;

    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mux_out", 32'(mux_out), 32'd0);
    check_eq("rst_chan_idx", 32'(chan_idx), 32'd0);
    check_eq("rst_last", 32'(last), 32'd0);
    check_eq("rst_sel_err", 32'(sel_err), 32'd0);
    check_eq("rst_pix_ready", 32'(pix_ready), 32'd1);
    reset = 1'b0;

    // Direct select, then zero and multi-hot selects.
    cycle(1'b1, 1'b0, 3'b010, 24'hAABBCC, 1'b1);
    cycle(1'b1, 1'b0, 3'b011, 24'h123456, 1'b1);
    check_eq("t1_mux_out", 32'(mux_out), 32'h0000_00BB);
    cycle(1'b1, 1'b0, 3'b000, 24'h654321, 1'b1);
    check_eq("t2_sel_err", 32'(sel_err), 32'd1);
    check_eq("t2_mux_out", 32'(mux_out), 32'h0000_00BB);
    cycle(1'b0, 1'b0, 3'b000, 24'h000000, 1'b1);
    cycle(1'b0, 1'b0, 3'b000, 24'h000000, 1'b1);

    // Serial back-to-back pixels.
    cycle(1'b1, 1'b1, 3'b000, 24'h112233, 1'b1);
    repeat (3) cycle(1'b1, 1'b1, 3'b000, 24'h445566, 1'b1);
    cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);
    check_eq("t3_first_of_second", 32'(mux_out), 32'h0000_0066);
    repeat (3) cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);

    // Serial backpressure on ch1.
    cycle(1'b1, 1'b1, 3'b000, 24'h112233, 1'b1);
    cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b0);
    check_eq("t4_hold_mux", 32'(mux_out), 32'h0000_0022);
    check_eq("t4_hold_idx", 32'(chan_idx), 32'd1);
    repeat (3) cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);

    // Mode changes to DIRECT while a serial pixel is in flight.
    cycle(1'b1, 1'b1, 3'b000, 24'hABCDEF, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 3'b001, 24'h010203, 1'b1);
    cycle(1'b0, 1'b0, 3'b000, 24'h000000, 1'b1);
    check_eq("t5_direct_after", 32'(mux_out), 32'h0000_0003);
    cycle(1'b0, 1'b0, 3'b000, 24'h000000, 1'b1);

    // Reset in the middle of a serial pixel.
    cycle(1'b1, 1'b1, 3'b000, 24'h112233, 1'b1);
    cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);
    cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_mux_out", 32'(mux_out), 32'd0);
    check_eq("t6_chan_idx", 32'(chan_idx), 32'd0);
    model_clear();
    @(posedge clk);
    #3;
    reset = 1'b0;
    cycle(1'b1, 1'b1, 3'b000, 24'h778899, 1'b1);
    cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);
    check_eq("t6_restart_ch0", 32'(mux_out), 32'h0000_0099);
    repeat (3) cycle(1'b0, 1'b1, 3'b000, 24'h000000, 1'b1);

    // Random traffic; an unaccepted pixel is held stable until taken.
    rv = 1'b0;
    rm = 1'b0;
    rs = 3'b001;
    rp = 24'h0;
    last_acc = 1'b0;
    repeat (600) begin
      if (!(rv && !last_acc)) begin
        rv = ($urandom_range(3) != 0);
        rm = 1'($urandom_range(1));
        rs = ($urandom_range(4) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(2));
        rp = 24'($urandom);
      end
      cycle(rv, rm, rs, rp, ($urandom_range(9) < 7));
    end
    repeat (6) cycle(1'b0, 1'b0, 3'b000, 24'h000000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
